apple1_mem_arbiter: RTL and testbench

Slot-based arbiter for the Apple-1 main RAM port. It shares one memory access per `mem_clken` slot among three masters: a built-in RAM eraser, the ROM/PRG downloader (buffered through a small FIFO), and the 6502. It sits between the downloader, CPU bus and `ram`, and replaces the combinational download/CPU mux. It also holds the CPU off the bus (`cpu_stall`) while the eraser or the downloader owns the port.

---
 rtl/apple1_mem_pkg.sv | 13 +
 rtl/dl_fifo.sv | 57 +++++
 rtl/apple1_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_apple1_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_mem_pkg.sv
// rtl/apple1_mem_pkg.sv - shared types and defaults for the Apple-1 RAM port arbiter
package apple1_mem_pkg;

    typedef enum logic [1:0] {
        OWN_CPU   = 2'd0,
        OWN_DL    = 2'd1,
        OWN_ERASE = 2'd2
    } owner_t;

    localparam logic [15:0] ERASE_END_DEFAULT   = 16'hBFFF;
    localparam logic [7:0]  ERASE_VALUE_DEFAULT = 8'h00;

endpackage

// File: rtl/dl_fifo.sv
// rtl/dl_fifo.sv - small synchronous FIFO buffering downloader writes
module dl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/apple1_mem_arbiter.sv
// rtl/apple1_mem_arbiter.sv - slot arbiter sharing the Apple-1 RAM between eraser, downloader and 6502
module apple1_mem_arbiter
    import apple1_mem_pkg::*;
#(
    parameter int                 ADDR_W         = 16,
    parameter int                 DATA_W         = 8,
    parameter logic [ADDR_W-1:0]  ERASE_END      = ADDR_W'(ERASE_END_DEFAULT),
    parameter logic [DATA_W-1:0]  ERASE_VALUE    = DATA_W'(ERASE_VALUE_DEFAULT),
    parameter bit                 ERASE_ON_RESET = 1'b1,
    parameter int                 FIFO_DEPTH     = 4
) (
    input  logic              sys_clock,
    input  logic              reset_n,
    input  logic              mem_clken,
    input  logic              erase_req,
    output logic              erase_busy,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,
    output logic              dl_overflow,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int     CW          = $clog2(FIFO_DEPTH) + 1;
    localparam owner_t OWNER_RESET = ERASE_ON_RESET ? OWN_ERASE : OWN_CPU;

    owner_t                     owner;
    owner_t                     owner_next;
    logic [ADDR_W-1:0]          erase_ptr;
    logic [ADDR_W-1:0]          erase_ptr_next;
    logic                       erase_busy_next;
    logic                       erase_accept;
    logic                       erase_step;
    logic                       overflow_next;
    logic                       dl_pop;
    logic                       dl_push_ok;
    logic                       dl_drop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CW-1:0]              fifo_count;
    logic [CW-1:0]              fifo_count_next;
    logic [ADDR_W+DATA_W-1:0]   fifo_head;

    dl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (sys_clock),
        .reset_n   (reset_n),
        .push      (dl_wr),
        .push_data ({dl_addr, dl_data}),
        .pop       (dl_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign dl_pop       = mem_clken && (owner == OWN_DL) && !fifo_empty;
    assign dl_push_ok   = dl_wr && (!fifo_full || dl_pop);
    assign dl_drop      = dl_wr && fifo_full && !dl_pop;
    assign erase_accept = erase_req && !erase_busy;
    assign erase_step   = mem_clken && (owner == OWN_ERASE) && erase_busy;

    // Eraser pointer/busy next state and the sticky overflow flag.
    always_comb begin
        erase_ptr_next  = erase_ptr;
        erase_busy_next = erase_busy;
        fifo_count_next = fifo_count + CW'(dl_push_ok) - CW'(dl_pop);
        if (erase_accept) begin
            erase_busy_next = 1'b1;
            erase_ptr_next  = '0;
        end else if (erase_step) begin
            if (erase_ptr == ERASE_END) begin
                erase_busy_next = 1'b0;
            end else begin
                erase_ptr_next = erase_ptr + 1'b1;
            end
        end
        overflow_next = (dl_overflow && !erase_accept) || dl_drop;
    end

    // Owner selection for the next slot from post-update state: erase beats download beats CPU.
    always_comb begin
        owner_next = owner;
        if (mem_clken) begin
            if (erase_busy_next) begin
                owner_next = OWN_ERASE;
            end else if (fifo_count_next != '0) begin
                owner_next = OWN_DL;
            end else begin
                owner_next = OWN_CPU;
            end
        end
    end

    // State registers: owner, eraser and overflow all return to reset values asynchronously.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            owner       <= OWNER_RESET;
            erase_ptr   <= '0;
            erase_busy  <= ERASE_ON_RESET;
            dl_overflow <= 1'b0;
        end else begin
            owner       <= owner_next;
            erase_ptr   <= erase_ptr_next;
            erase_busy  <= erase_busy_next;
            dl_overflow <= overflow_next;
        end
    end

    // Memory request mux driven by the current slot owner.
    always_comb begin
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
        mem_wr   = cpu_wr;
        mem_rd   = cpu_rd;
        case (owner)
            OWN_ERASE: begin
                mem_addr = erase_ptr;
                mem_din  = ERASE_VALUE;
                mem_wr   = 1'b1;
                mem_rd   = 1'b0;
            end
            OWN_DL: begin
                mem_addr = fifo_head[ADDR_W+DATA_W-1:DATA_W];
                mem_din  = fifo_head[DATA_W-1:0];
                mem_wr   = 1'b1;
                mem_rd   = 1'b0;
            end
            default: begin
                mem_addr = cpu_addr;
                mem_din  = cpu_din;
                mem_wr   = cpu_wr;
                mem_rd   = cpu_rd;
            end
        endcase
    end

    assign cpu_stall = (owner != OWN_CPU);
    assign cpu_dout  = (owner == OWN_CPU) ? mem_dout : '0;

endmodule

// File: tb/tb_apple1_mem_arbiter.sv
// tb/tb_apple1_mem_arbiter.sv - scoreboard bench for apple1_mem_arbiter
module tb_apple1_mem_arbiter;

    logic        sys_clock = 1'b0;
    logic        reset_n   = 1'b1;
    logic        mem_clken = 1'b0;
    logic        erase_req = 1'b0;
    logic        erase_busy;
    logic        dl_wr     = 1'b0;
    logic [15:0] dl_addr   = '0;
    logic [7:0]  dl_data   = '0;
    logic        dl_overflow;
    logic [15:0] cpu_addr  = '0;
    logic [7:0]  cpu_din   = '0;
    logic        cpu_rd    = 1'b0;
    logic        cpu_wr    = 1'b0;
    logic [7:0]  cpu_dout;
    logic        cpu_stall;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_wr;
    logic        mem_rd;
    logic [7:0]  mem_dout  = '0;

    apple1_mem_arbiter #(
        .ADDR_W         (16),
        .DATA_W         (8),
        .ERASE_END      (16'h000F),
        .ERASE_VALUE    (8'h00),
        .ERASE_ON_RESET (1'b1),
        .FIFO_DEPTH     (4)
    ) dut (
        .sys_clock   (sys_clock),
        .reset_n     (reset_n),
        .mem_clken   (mem_clken),
        .erase_req   (erase_req),
        .erase_busy  (erase_busy),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_overflow (dl_overflow),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_dout    (cpu_dout),
        .cpu_stall   (cpu_stall),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .mem_dout    (mem_dout)
    );

    always #5 sys_clock = ~sys_clock;

    logic [7:0] ram [0:65535];

    always @(posedge sys_clock) begin
        if (reset_n && mem_clken) begin
            if (mem_wr) ram[mem_addr] <= mem_din;
            if (mem_rd) mem_dout <= ram[mem_addr];
        end
    end

    int          checks = 0;
    int          passes = 0;
    int          stall_slots = 0;
    int          cyc = 0;
    bit          clken_en = 1'b1;
    logic [24:0] wq [$];
    logic [7:0]  rq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge sys_clock);
        #1;
        cyc++;
        mem_clken = clken_en && ((cyc % 4) == 3);
    endtask

    task automatic exp_write(input logic [15:0] a, input logic [7:0] d, input logic stall);
        wq.push_back({stall, a, d});
    endtask

    task automatic wait_busy_low(input string name, input int limit);
        int n = 0;
        while (erase_busy && n < limit) begin
            tick();
            n++;
        end
        check(name, {31'd0, erase_busy}, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every executed memory write and on CPU read data.
    initial begin
        bit rd_pending = 1'b0;
        forever begin
            @(negedge sys_clock);
            if (rd_pending) begin
                rd_pending = 1'b0;
                if (rq.size() > 0) begin
                    check("cpu_dout", {24'd0, cpu_dout}, {24'd0, rq.pop_front()});
                end else begin
                    checks++;
                    $display("FAIL unexpected_read: got %h expected none", cpu_dout);
                end
            end
            if (reset_n && mem_clken) begin
                if (cpu_stall) stall_slots++;
                if (mem_wr) begin
                    if (wq.size() > 0) begin
                        check("mem_write", {7'd0, cpu_stall, mem_addr, mem_din}, {7'd0, wq.pop_front()});
                    end else begin
                        checks++;
                        $display("FAIL unexpected_write: got %h expected none", {cpu_stall, mem_addr, mem_din});
                    end
                end
                if (mem_rd && !cpu_stall) rd_pending = 1'b1;
            end
        end
    end

    initial begin
        int s0;
        int n;
        #1 reset_n = 1'b0;
        #1;
        check("reset_busy", {31'd0, erase_busy}, 32'd1);
        check("reset_stall", {31'd0, cpu_stall}, 32'd1);
        check("reset_ovf", {31'd0, dl_overflow}, 32'd0);
        check("reset_mem_wr", {31'd0, mem_wr}, 32'd1);
        check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);

        // Power-on erase of 0..F
        for (int i = 0; i < 16; i++) exp_write(16'(i), 8'h00, 1'b1);
        tick();
        tick();
        reset_n = 1'b1;
        s0 = stall_slots;
        wait_busy_low("erase1_done", 200);
        check("erase1_slots", stall_slots - s0, 32'd16);
        check("erase1_owner_cpu", {31'd0, cpu_stall}, 32'd0);

        // Two back-to-back downloads
        tick();
        s0 = stall_slots;
        exp_write(16'h0300, 8'hA9, 1'b1);
        exp_write(16'h0301, 8'h00, 1'b1);
        dl_wr = 1'b1; dl_addr = 16'h0300; dl_data = 8'hA9;
        tick();
        dl_addr = 16'h0301; dl_data = 8'h00;
        tick();
        dl_wr = 1'b0;
        repeat (20) tick();
        check("dl_slots", stall_slots - s0, 32'd2);
        check("dl_release", {31'd0, cpu_stall}, 32'd0);

        // Overflow: five pushes with no slot in between
        clken_en = 1'b0;
        mem_clken = 1'b0;
        for (int i = 0; i < 4; i++) exp_write(16'h0400 + 16'(i), 8'h10 + 8'(i), 1'b1);
        dl_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dl_addr = 16'h0400 + 16'(i);
            dl_data = 8'h10 + 8'(i);
            tick();
        end
        dl_wr = 1'b0;
        check("ovf_set", {31'd0, dl_overflow}, 32'd1);
        check("fifo_full_count", {29'd0, dut.u_fifo.count}, 32'd4);
        clken_en = 1'b1;
        repeat (30) tick();
        check("ovf_sticky", {31'd0, dl_overflow}, 32'd1);
        check("ovf_drain_stall", {31'd0, cpu_stall}, 32'd0);

        // Erase request clears overflow; download during erase waits until after it
        for (int i = 0; i < 16; i++) exp_write(16'(i), 8'h00, 1'b1);
        exp_write(16'h0500, 8'h77, 1'b1);
        s0 = stall_slots;
        erase_req = 1'b1;
        tick();
        erase_req = 1'b0;
        check("erase_req_clears_ovf", {31'd0, dl_overflow}, 32'd0);
        check("erase_req_busy", {31'd0, erase_busy}, 32'd1);
        tick();
        dl_wr = 1'b1; dl_addr = 16'h0500; dl_data = 8'h77;
        tick();
        dl_wr = 1'b0;
        wait_busy_low("erase2_done", 300);
        repeat (8) tick();
        check("erase2_dl_slots", stall_slots - s0, 32'd17);
        check("erase2_release", {31'd0, cpu_stall}, 32'd0);

        // CPU write then read back
        exp_write(16'h0200, 8'h55, 1'b0);
        rq.push_back(8'h55);
        while (!mem_clken) tick();
        cpu_wr = 1'b1; cpu_addr = 16'h0200; cpu_din = 8'h55;
        tick();
        cpu_wr = 1'b0; cpu_din = 8'h00;
        while (!mem_clken) tick();
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        repeat (4) tick();
        check("cpu_read_seen", rq.size(), 32'd0);

        // Asynchronous reset in the middle of an erase with a loaded FIFO
        for (int i = 0; i < 7; i++) exp_write(16'(i), 8'h00, 1'b1);
        erase_req = 1'b1;
        tick();
        erase_req = 1'b0;
        dl_wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dl_addr = 16'h0600 + 16'(i);
            dl_data = 8'h20 + 8'(i);
            tick();
        end
        dl_wr = 1'b0;
        check("ovf_during_erase", {31'd0, dl_overflow}, 32'd1);
        n = 0;
        while (dut.erase_ptr != 16'd7 && n < 200) begin
            tick();
            n++;
        end
        check("ptr_reached_7", {16'd0, dut.erase_ptr}, 32'd7);
        reset_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, erase_busy}, 32'd1);
        check("rst_ptr", {16'd0, dut.erase_ptr}, 32'd0);
        check("rst_fifo_empty", {31'd0, dut.u_fifo.empty}, 32'd1);
        check("rst_ovf", {31'd0, dl_overflow}, 32'd0);
        check("rst_stall", {31'd0, cpu_stall}, 32'd1);
        for (int i = 0; i < 16; i++) exp_write(16'(i), 8'h00, 1'b1);
        tick();
        tick();
        reset_n = 1'b1;
        wait_busy_low("erase3_done", 200);
        repeat (12) tick();
        check("erase3_release", {31'd0, cpu_stall}, 32'd0);

        check("wq_empty", wq.size(), 32'd0);
        check("rq_empty", rq.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
